reg_xfer_ctrl: RTL and testbench

Round-robin controller that shares the bank of reg8bit registers between several requesters. Each requester asks for either an immediate LOAD into a destination register or a MOVE from one register to another. The controller drives the registers' shared data input bus and one-hot write enables, and acknowledges each request when it completes. It sits between the RichieJr sequencing logic and the register bank.

---
 rtl/reg_xfer_ctrl_pkg.sv | 20 ++
 rtl/reg_xfer_ctrl_rr_arbiter.sv | 29 ++
 rtl/reg_xfer_ctrl.sv | 108 ++++++++++
 tb/tb_reg_xfer_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_xfer_ctrl_pkg.sv
// Shared definitions for the register-transfer controller: op codes, FSM
// state encodings, default widths and an index-width helper.
package reg_xfer_ctrl_pkg;

    localparam int DEF_W  = 8;
    localparam int DEF_AW = 2;

    localparam logic OP_LOAD = 1'b0;
    localparam logic OP_MOVE = 1'b1;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_READ  = 2'b01;
    localparam logic [1:0] ST_WRITE = 2'b10;

    // Index width that stays legal when only one requester exists.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_xfer_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after ptr,
// wrapping around the requester ring.
module rr_arbiter
    import reg_xfer_ctrl_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int GW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   ptr,
    output logic            gnt_valid,
    output logic [GW-1:0]   gnt_idx
);

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        // Walk offsets from farthest to nearest so the nearest hit wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            int w_i;
            w_i = (int'(ptr) + k) % NREQ;
            if (req[w_i]) begin
                gnt_valid = 1'b1;
                gnt_idx   = GW'(w_i);
            end
        end
    end

endmodule

// File: rtl/reg_xfer_ctrl.sv
// Round-robin LOAD/MOVE controller sharing one register bank between
// several requesters; drives the bank's data bus and one-hot enables.
module reg_xfer_ctrl
    import reg_xfer_ctrl_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int NREG = 4,
    parameter int AW   = DEF_AW,
    parameter int W    = DEF_W
) (
    input  logic               clk,
    input  logic               res,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_op,
    input  logic [NREQ*AW-1:0] req_src,
    input  logic [NREQ*AW-1:0] req_dst,
    input  logic [NREQ*W-1:0]  req_imm,
    output logic [NREQ-1:0]    ack,
    output logic               busy,
    input  logic [NREG*W-1:0]  reg_q,
    output logic [NREG-1:0]    reg_en,
    output logic [W-1:0]       reg_d
);

    localparam int GW = idx_w(NREQ);

    logic [1:0]    r_state;
    logic [GW-1:0] r_ptr;
    logic [GW-1:0] r_gnt;
    logic          r_op;
    logic [AW-1:0] r_src;
    logic [AW-1:0] r_dst;
    logic [W-1:0]  r_data;

    logic          w_gnt_valid;
    logic [GW-1:0] w_gnt_idx;
    logic [W-1:0]  w_src_q;
    logic          w_write;

    rr_arbiter #(
        .NREQ (NREQ),
        .GW   (GW)
    ) u_arb (
        .req       (req),
        .ptr       (r_ptr),
        .gnt_valid (w_gnt_valid),
        .gnt_idx   (w_gnt_idx)
    );

    assign w_src_q = reg_q[r_src*W +: W];

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_op    <= OP_LOAD;
            r_src   <= '0;
            r_dst   <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        r_gnt <= w_gnt_idx;
                        r_op  <= req_op[w_gnt_idx];
                        r_src <= req_src[w_gnt_idx*AW +: AW];
                        r_dst <= req_dst[w_gnt_idx*AW +: AW];
                        if (req_op[w_gnt_idx] == OP_MOVE) begin
                            r_state <= ST_READ;
                        end else begin
                            r_data  <= req_imm[w_gnt_idx*W +: W];
                            r_state <= ST_WRITE;
                        end
                    end
                end
                ST_READ: begin
                    if (r_op == OP_MOVE) begin
                        r_data <= w_src_q;
                    end
                    r_state <= ST_WRITE;
                end
                ST_WRITE: begin
                    // Next search starts just past the requester just served.
                    r_ptr   <= (r_gnt == GW'(NREQ - 1)) ? '0 : r_gnt + 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_write = (r_state == ST_WRITE);

    always_comb begin
        reg_en = '0;
        reg_d  = '0;
        ack    = '0;
        if (w_write) begin
            reg_en = NREG'(1) << r_dst;
            reg_d  = r_data;
            ack    = NREQ'(1) << r_gnt;
        end
    end

    assign busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Directed self-checking bench for reg_xfer_ctrl with a behavioural
// four-entry register bank attached to reg_en/reg_d/reg_q.
module tb_reg_xfer_ctrl;

    logic        clk = 1'b0;
    logic        res;
    logic [3:0]  req;
    logic [3:0]  req_op;
    logic [7:0]  req_src;
    logic [7:0]  req_dst;
    logic [31:0] req_imm;
    logic [3:0]  ack;
    logic        busy;
    logic [31:0] reg_q;
    logic [3:0]  reg_en;
    logic [7:0]  reg_d;

    logic [7:0]  bank [0:3] = '{8'h00, 8'h00, 8'h00, 8'h00};

    int n_checks = 0;
    int n_errors = 0;

    reg_xfer_ctrl #(
        .NREQ (4),
        .NREG (4),
        .AW   (2),
        .W    (8)
    ) dut (
        .clk     (clk),
        .res     (res),
        .req     (req),
        .req_op  (req_op),
        .req_src (req_src),
        .req_dst (req_dst),
        .req_imm (req_imm),
        .ack     (ack),
        .busy    (busy),
        .reg_q   (reg_q),
        .reg_en  (reg_en),
        .reg_d   (reg_d)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int j = 0; j < 4; j++) begin
            if (reg_en[j]) bank[j] <= reg_d;
        end
    end

    assign reg_q = {bank[3], bank[2], bank[1], bank[0]};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic op, input logic [1:0] src,
                           input logic [1:0] dst, input logic [7:0] imm);
        req_op[i]         = op;
        req_src[i*2 +: 2] = src;
        req_dst[i*2 +: 2] = dst;
        req_imm[i*8 +: 8] = imm;
    endtask

    initial begin
        // Reset with scattered requests pending
        res     = 1'b0;
        req     = 4'b1011;
        req_op  = 4'b0110;
        req_src = 8'hE4;
        req_dst = 8'h1B;
        req_imm = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        chk("rst_reg_en", 32'(reg_en), 32'h0);
        chk("rst_reg_d",  32'(reg_d),  32'h0);
        chk("rst_ack",    32'(ack),    32'h0);
        chk("rst_busy",   32'(busy),   32'h0);
        req = 4'b0000;
        res = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy), 32'h0);
        end
        chk("idle_reg_en", 32'(reg_en), 32'h0);

        // LOAD 0x69 into register 2 from requester 0
        set_req(0, 1'b0, 2'd0, 2'd2, 8'h69);
        req = 4'b0001;
        @(negedge clk);
        chk("load_reg_en", 32'(reg_en), 32'h4);
        chk("load_reg_d",  32'(reg_d),  32'h69);
        chk("load_ack",    32'(ack),    32'h1);
        chk("load_busy",   32'(busy),   32'h1);
        req = 4'b0000;
        @(negedge clk);
        chk("load_ack_end", 32'(ack),     32'h0);
        chk("load_bank2",   32'(bank[2]), 32'h69);

        // MOVE register 2 -> 3 from requester 1
        set_req(1, 1'b1, 2'd2, 2'd3, 8'h00);
        req = 4'b0010;
        @(negedge clk);
        chk("move_rd_busy",   32'(busy),   32'h1);
        chk("move_rd_reg_en", 32'(reg_en), 32'h0);
        chk("move_rd_ack",    32'(ack),    32'h0);
        @(negedge clk);
        chk("move_reg_en", 32'(reg_en), 32'h8);
        chk("move_reg_d",  32'(reg_d),  32'h69);
        chk("move_ack",    32'(ack),    32'h2);
        req = 4'b0000;
        @(negedge clk);
        chk("move_bank3", 32'(bank[3]), 32'h69);
        chk("move_idle",  32'(busy),    32'h0);

        // Pulse reset so the round-robin pointer restarts at requester 0
        res = 1'b0;
        @(negedge clk);
        chk("rst2_busy", 32'(busy), 32'h0);
        res = 1'b1;

        // Four simultaneous LOADs served 0,1,2,3
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 2'd0, 2'(i), 8'(8'h10 + i));
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr_ack",    32'(ack),    32'(1 << k));
            chk("rr_reg_en", 32'(reg_en), 32'(1 << k));
            chk("rr_reg_d",  32'(reg_d),  32'(8'h10 + k));
            req[k] = 1'b0;
            @(negedge clk);
            chk("rr_gap_ack", 32'(ack), 32'h0);
        end
        for (int i = 0; i < 4; i++) chk("rr_bank", 32'(bank[i]), 32'(8'h10 + i));

        // Requesters 0 and 1 held high alternate
        set_req(0, 1'b0, 2'd0, 2'd0, 8'hA0);
        set_req(1, 1'b0, 2'd0, 2'd1, 8'hB1);
        req = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("fair_ack", 32'(ack), (k % 2 == 0) ? 32'h1 : 32'h2);
            @(negedge clk);
            chk("fair_gap", 32'(ack), 32'h0);
        end
        req = 4'b0000;
        @(negedge clk);
        chk("fair_bank0", 32'(bank[0]), 32'hA0);
        chk("fair_bank1", 32'(bank[1]), 32'hB1);

        // Reset during READ of a MOVE 0 -> 3 from requester 2
        set_req(2, 1'b1, 2'd0, 2'd3, 8'h00);
        req = 4'b0100;
        @(negedge clk);
        chk("mid_rd_busy", 32'(busy), 32'h1);
        res = 1'b0;
        #1;
        chk("mid_rst_busy",   32'(busy),   32'h0);
        chk("mid_rst_reg_en", 32'(reg_en), 32'h0);
        chk("mid_rst_ack",    32'(ack),    32'h0);
        req = 4'b0000;
        @(negedge clk);
        chk("mid_bank3_kept", 32'(bank[3]), 32'h13);
        chk("mid_rst_ack2",   32'(ack),     32'h0);
        res = 1'b1;

        // Pointer back at 0: requester 1 beats the re-presented requester 2
        set_req(1, 1'b0, 2'd0, 2'd2, 8'h5A);
        req = 4'b0110;
        @(negedge clk);
        chk("post_ack1",    32'(ack),    32'h2);
        chk("post_reg_en1", 32'(reg_en), 32'h4);
        chk("post_reg_d1",  32'(reg_d),  32'h5A);
        req[1] = 1'b0;
        @(negedge clk);
        chk("post_gap", 32'(ack), 32'h0);
        @(negedge clk);
        chk("post_rd_reg_en", 32'(reg_en), 32'h0);
        @(negedge clk);
        chk("post_ack2",    32'(ack),    32'h4);
        chk("post_reg_en2", 32'(reg_en), 32'h8);
        chk("post_reg_d2",  32'(reg_d),  32'hA0);
        req = 4'b0000;
        @(negedge clk);
        chk("post_bank3", 32'(bank[3]), 32'hA0);
        chk("post_bank2", 32'(bank[2]), 32'h5A);

        // MOVE onto itself from requester 3
        set_req(3, 1'b1, 2'd1, 2'd1, 8'h00);
        req = 4'b1000;
        repeat (2) @(negedge clk);
        chk("self_ack",    32'(ack),    32'h8);
        chk("self_reg_en", 32'(reg_en), 32'h2);
        chk("self_reg_d",  32'(reg_d),  32'hB1);
        req = 4'b0000;
        @(negedge clk);
        chk("self_bank1", 32'(bank[1]), 32'hB1);
        chk("self_idle",  32'(busy),    32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
